// File: rtl/mstage_lsu.sv
// mstage_lsu: M-stage load/store unit issuing one AXI4-Lite access per op and returning results to W.
module mstage_lsu #(
    parameter bit FAULT_ON_MISALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        mvalidM,
    input  logic        mwenM,
    input  logic [7:0]  mwmaskM,
    input  logic [2:0]  mrtypeM,
    input  logic [31:0] ALU_resultM,
    input  logic [31:0] src2M,
    input  logic [4:0]  rdM,
    input  logic [31:0] pcM,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] rdataW,
    output logic [31:0] aluW,
    output logic [4:0]  rdW,
    output logic [31:0] pcW,
    output logic        fault,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] src2_q;
    logic [3:0]  mask_q;
    logic [2:0]  rtype_q;
    logic        aw_done, w_done;
    logic [1:0]  in_off, off;
    logic        mis_ld, mis_st, misalign, accept;
    logic [31:0] shifted, ext;
    logic        unused;
    assign unused   = ^mwmaskM[7:4];
    assign in_off   = ALU_resultM[1:0];
    assign off      = aluW[1:0];
    assign mis_ld   = (mrtypeM == 3'd1 || mrtypeM == 3'd5) ? in_off[0] :
                      (mrtypeM == 3'd0 || mrtypeM == 3'd4) ? 1'b0 : |in_off;
    assign mis_st   = (mwmaskM[3:0] == 4'hF) ? |in_off :
                      (mwmaskM[3:0] == 4'h3) ? in_off[0] : 1'b0;
    assign misalign = FAULT_ON_MISALIGN && (mwenM ? mis_st : (mvalidM && mis_ld));
    assign accept   = s_valid && state == IDLE;
    assign s_ready  = state == IDLE;
    assign m_valid  = state == DONE;
    assign arvalid  = state == RADDR;
    assign rready   = state == RDATA;
    assign awvalid  = state == WREQ && !aw_done;
    assign wvalid   = state == WREQ && !w_done;
    assign bready   = state == WRESP;
    assign araddr   = {aluW[31:2], 2'b00};
    assign awaddr   = {aluW[31:2], 2'b00};
    assign wdata    = src2_q << {off, 3'b000};
    assign wstrb    = mask_q << off;
    assign shifted  = rdata >> {off, 3'b000};
    assign ext      = (rtype_q == 3'd0) ? {{24{shifted[7]}}, shifted[7:0]} :
                      (rtype_q == 3'd1) ? {{16{shifted[15]}}, shifted[15:0]} :
                      (rtype_q == 3'd4) ? {24'd0, shifted[7:0]} :
                      (rtype_q == 3'd5) ? {16'd0, shifted[15:0]} : shifted;
    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    // Next-state logic; a store wins over a load, a faulting misalign skips the bus
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (s_valid) state_nx = misalign ? DONE : mwenM ? WREQ : mvalidM ? RADDR : DONE;
            RADDR:   if (arready) state_nx = RDATA;
            RDATA:   if (rvalid) state_nx = DONE;
            WREQ:    if ((aw_done || awready) && (w_done || wready)) state_nx = WRESP;
            WRESP:   if (bvalid) state_nx = DONE;
            DONE:    if (m_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // Operand capture, write-channel acceptance tracking and result/fault latching
    always_ff @(posedge clk) begin
        if (rst) begin
            aluW    <= '0;
            rdW     <= '0;
            pcW     <= '0;
            rdataW  <= '0;
            fault   <= 1'b0;
            src2_q  <= '0;
            mask_q  <= '0;
            rtype_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (accept) begin
                aluW    <= ALU_resultM;
                rdW     <= rdM;
                pcW     <= pcM;
                src2_q  <= src2M;
                mask_q  <= mwmaskM[3:0];
                rtype_q <= mrtypeM;
                rdataW  <= '0;
                fault   <= misalign;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready) w_done <= 1'b1;
            if (state == RDATA && rvalid) begin
                fault  <= rresp != 2'b00;
                rdataW <= (rresp != 2'b00) ? 32'd0 : ext;
            end
            if (state == WRESP && bvalid) fault <= bresp != 2'b00;
        end
    end
endmodule

// File: tb/tb_mstage_lsu.sv
// tb_mstage_lsu: scoreboard bench for mstage_lsu with a behavioural AXI4-Lite slave.
module tb_mstage_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0, s_ready;
    logic        mvalidM = 1'b0, mwenM = 1'b0;
    logic [7:0]  mwmaskM = '0;
    logic [2:0]  mrtypeM = '0;
    logic [31:0] ALU_resultM = '0, src2M = '0, pcM = '0;
    logic [4:0]  rdM = '0;
    logic        m_valid, m_ready = 1'b1;
    logic [31:0] rdataW, aluW, pcW;
    logic [4:0]  rdW;
    logic        fault;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int errors = 0, checks = 0;
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, w_wait = 0;
    int w_delay = 0;
    bit r_hold = 0;
    logic [31:0] rd_val = '0, last_araddr = '0, last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [1:0]  rd_resp = '0, b_resp = '0;

    typedef struct {
        logic [31:0] rd_data;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        f;
    } exp_t;
    exp_t q[$];

    mstage_lsu #(.FAULT_ON_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .mvalidM(mvalidM), .mwenM(mwenM), .mwmaskM(mwmaskM), .mrtypeM(mrtypeM),
        .ALU_resultM(ALU_resultM), .src2M(src2M), .rdM(rdM), .pcM(pcM),
        .m_valid(m_valid), .m_ready(m_ready), .rdataW(rdataW), .aluW(aluW),
        .rdW(rdW), .pcW(pcW), .fault(fault),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural slave: zero-wait except for the W channel delay and an optional R hold-off
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            arready = arvalid;
            if (arvalid) begin ar_cnt++; last_araddr = araddr; end
            rvalid = rready && !r_hold;
            rdata = rd_val;
            rresp = rd_resp;
            awready = awvalid;
            if (awvalid) begin aw_cnt++; last_awaddr = awaddr; end
            if (wvalid) begin
                wready = (w_wait >= w_delay);
                w_wait = wready ? 0 : w_wait + 1;
                if (wready) begin w_cnt++; last_wdata = wdata; last_wstrb = wstrb; end
            end else begin
                wready = 0;
                w_wait = 0;
            end
            bvalid = bready;
            bresp = b_resp;
            if (bready) b_cnt++;
        end
    end

    // Monitor: every accepted W-stage result is checked against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got rd=%0d alu=%h expected no result", rdW, aluW);
                end else begin
                    e = q.pop_front();
                    chk("rdataW", rdataW, e.rd_data);
                    chk("aluW", aluW, e.alu);
                    chk("rdW", {27'd0, rdW}, {27'd0, e.rd});
                    chk("pcW", pcW, e.pc);
                    chk("fault", {31'd0, fault}, {31'd0, e.f});
                end
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [7:0] mk, input logic [2:0] rt,
                         input logic [31:0] ad, input logic [31:0] s2, input logic [4:0] rd,
                         input logic [31:0] pc, input bit push, input logic [31:0] erd, input logic ef);
        int n = 0;
        s_valid = 1; mvalidM = ld; mwenM = st; mwmaskM = mk; mrtypeM = rt;
        ALU_resultM = ad; src2M = s2; rdM = rd; pcM = pc;
        while (!s_ready && n < 50) begin @(negedge clk); n++; end
        chk("issue_accept", {31'd0, s_ready}, 32'd1);
        if (push) q.push_back('{erd, ad, rd, pc, ef});
        @(negedge clk);
        s_valid = 0;
    endtask

    task automatic wait_mv(input string name, input int exp);
        int n = 0;
        while (!m_valid && n < 30) begin @(negedge clk); n++; end
        chk(name, n, exp);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        int a0, b0, w0;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, aw0, b0;
        repeat (3) @(negedge clk);
        rst = 0;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_axi_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("rst_outputs", rdataW | aluW | pcW | {27'd0, rdW} | {31'd0, fault}, 32'd0);

        // 1: non-memory op, one-cycle latency, no bus traffic
        a0 = ar_cnt; aw0 = aw_cnt;
        issue(0, 0, 8'h0, 3'd0, 32'h1234, 32'h0, 5'd5, 32'h100, 1, 32'h0, 0);
        wait_mv("alu_latency", 0);
        drain();
        chk("alu_no_axi", ar_cnt + aw_cnt, a0 + aw0);

        // 2: byte/half/word loads with sign and zero extension
        rd_val = 32'h80FF_0000;
        issue(1, 0, 8'h0, 3'd0, 32'h8000_0003, 32'h0, 5'd6, 32'h104, 1, 32'hFFFF_FF80, 0);
        wait_mv("load_latency", 2);
        drain();
        chk("lb_araddr", last_araddr, 32'h8000_0000);
        issue(1, 0, 8'h0, 3'd4, 32'h8000_0003, 32'h0, 5'd7, 32'h108, 1, 32'h0000_0080, 0);
        drain();
        issue(1, 0, 8'h0, 3'd1, 32'h8000_0002, 32'h0, 5'd8, 32'h10C, 1, 32'hFFFF_80FF, 0);
        drain();
        issue(1, 0, 8'h0, 3'd5, 32'h8000_0002, 32'h0, 5'd8, 32'h110, 1, 32'h0000_80FF, 0);
        drain();
        issue(1, 0, 8'h0, 3'd2, 32'h8000_0008, 32'h0, 5'd9, 32'h114, 1, 32'h80FF_0000, 0);
        drain();
        rd_resp = 2'd2;
        issue(1, 0, 8'h0, 3'd2, 32'h8000_000C, 32'h0, 5'd9, 32'h118, 1, 32'h0, 1);
        drain();
        rd_resp = 2'd0;

        // 3: SH at offset 2 with AW accepted before W; upper mask bits are ignored
        w_delay = 2; aw0 = aw_cnt; b0 = b_cnt;
        issue(0, 1, 8'hF3, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 5'd0, 32'h11C, 1, 32'h0, 0);
        drain();
        chk("sh_wdata", last_wdata, 32'hABCD_0000);
        chk("sh_wstrb", {28'd0, last_wstrb}, 32'hC);
        chk("sh_awaddr", last_awaddr, 32'h8000_0000);
        chk("sh_aw_once", aw_cnt - aw0, 1);
        chk("sh_b_once", b_cnt - b0, 1);
        w_delay = 0;
        issue(0, 1, 8'h0F, 3'd2, 32'h8000_0004, 32'h1122_3344, 5'd0, 32'h120, 1, 32'h0, 0);
        wait_mv("store_latency", 2);
        drain();
        chk("sw_wdata", last_wdata, 32'h1122_3344);
        chk("sw_wstrb", {28'd0, last_wstrb}, 32'hF);
        issue(0, 1, 8'h01, 3'd0, 32'h8000_0003, 32'h0000_00AB, 5'd0, 32'h124, 1, 32'h0, 0);
        drain();
        chk("sb_wdata", last_wdata, 32'hAB00_0000);
        chk("sb_wstrb", {28'd0, last_wstrb}, 32'h8);
        b_resp = 2'd2;
        issue(0, 1, 8'h0F, 3'd2, 32'h8000_0010, 32'h5, 5'd0, 32'h128, 1, 32'h0, 1);
        drain();
        b_resp = 2'd0;

        // 4: misaligned LW/SW fault without bus access; the following op is clean
        a0 = ar_cnt; aw0 = aw_cnt;
        issue(1, 0, 8'h0, 3'd2, 32'h8000_0001, 32'h0, 5'd10, 32'h12C, 1, 32'h0, 1);
        wait_mv("misalign_latency", 0);
        drain();
        chk("misalign_no_ar", ar_cnt, a0);
        issue(0, 1, 8'h0F, 3'd2, 32'h8000_0002, 32'h77, 5'd0, 32'h130, 1, 32'h0, 1);
        drain();
        chk("misalign_no_aw", aw_cnt, aw0);
        issue(0, 0, 8'h0, 3'd0, 32'h4321, 32'h0, 5'd11, 32'h134, 1, 32'h0, 0);
        drain();

        // 5: back-pressure holds DONE and its outputs
        m_ready = 0;
        issue(0, 0, 8'h0, 3'd0, 32'h5555, 32'h0, 5'd9, 32'h200, 1, 32'h0, 0);
        wait_mv("bp_latency", 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {aluW[15:0], 3'd0, rdW, 6'd0, m_valid, s_ready}, {16'h5555, 3'd0, 5'd9, 6'd0, 1'b1, 1'b0});
        end
        m_ready = 1;
        drain();
        chk("bp_release", {30'd0, m_valid, s_ready}, 32'd1);

        // 6: reset in the middle of a read, then a fresh load
        r_hold = 1;
        issue(1, 0, 8'h0, 3'd2, 32'h8000_0010, 32'h0, 5'd12, 32'h300, 0, 32'h0, 0);
        @(negedge clk);
        chk("rdata_state", {31'd0, rready}, 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_state", {28'd0, s_ready, rready, m_valid, arvalid}, 32'h8);
        chk("midrst_outputs", aluW | pcW | {27'd0, rdW}, 32'd0);
        r_hold = 0;
        rd_val = 32'hCAFE_BABE;
        issue(1, 0, 8'h0, 3'd0, 32'h8000_0021, 32'h0, 5'd13, 32'h304, 1, 32'hFFFF_FFBA, 0);
        wait_mv("fresh_latency", 2);
        drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
